// File: rtl/alu.sv
// Registered ALU: add, subtract, AND, OR with a signed-overflow flag.
// Operands and opcode are sampled on the rising edge; Y/OVF appear one cycle later.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OP_SEL,
  output logic [WIDTH-1:0] Y,
  output logic             OVF
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam int MSB = WIDTH - 1;

  op_e              op;
  logic [WIDTH-1:0] b_operand;
  logic [WIDTH-1:0] carry_in;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] y_next;
  logic             ovf_next;

  assign op = op_e'(OP_SEL);

  // One adder serves both ADD and SUB: subtraction is A + ~B + 1.
  always_comb begin
    b_operand = (op == OP_SUB) ? ~B : B;
    carry_in  = (op == OP_SUB) ? WIDTH'(1) : '0;
    sum       = A + b_operand + carry_in;
    // Signed overflow: same-signed adder inputs giving a result of the other sign.
    sum_ovf   = (A[MSB] == b_operand[MSB]) && (sum[MSB] != A[MSB]);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    y_next   = '0;
    ovf_next = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        y_next   = sum;
        ovf_next = sum_ovf;
      end
      OP_AND: y_next = A & B;
      OP_OR:  y_next = A | B;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      Y   <= '0;
      OVF <= 1'b0;
    end else begin
      Y   <= y_next;
      OVF <= ovf_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases, mid-stream reset,
// then 1000 randomized cycles against a signed-integer reference model.
module tb_alu;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] y;
  logic             ovf;

  int n_compared   = 0;
  int n_mismatched = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (a),
    .B      (b),
    .OP_SEL (op_sel),
    .Y      (y),
    .OVF    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got ovf=%0b y=%02h, want ovf=%0b y=%02h",
               tag, observed[8], observed[7:0], expected[8], expected[7:0]);
    end
  endtask

  // Reference: signed integer arithmetic, overflow when the true result
  // leaves the 8-bit two's-complement range.
  function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [1:0] mop, input logic mrst);
    int sa, sb, r;
    logic [7:0] ry;
    logic       rovf;
    if (mrst) return 9'h000;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    rovf = 1'b0;
    case (mop)
      2'b00: begin r = sa + sb; rovf = (r > 127) || (r < -128); ry = r[7:0]; end
      2'b01: begin r = sa - sb; rovf = (r > 127) || (r < -128); ry = r[7:0]; end
      2'b10: ry = ma & mb;
      default: ry = ma | mb;
    endcase
    return {rovf, ry};
  endfunction

  // Drive inputs, take one edge, sample #1 later and compare.
  task automatic step(input string tag, input logic rst, input logic [7:0] sa,
                      input logic [7:0] sb, input logic [1:0] sop,
                      input logic [7:0] ey, input logic eovf);
    reset  = rst;
    a      = sa;
    b      = sb;
    op_sel = sop;
    @(posedge clk);
    #1;
    check(tag, {ovf, y}, {eovf, ey});
  endtask

  initial begin
    logic [8:0] expected;
    logic       rst_r;
    logic [7:0] ra, rb;
    logic [1:0] rop;

    // Reset held for two edges with inputs that would otherwise give FE.
    step("reset_edge1", 1'b1, 8'hFF, 8'hFF, 2'b00, 8'h00, 1'b0);
    step("reset_edge2", 1'b1, 8'hFF, 8'hFF, 2'b00, 8'h00, 1'b0);
    step("post_reset",  1'b0, 8'hFF, 8'hFF, 2'b00, 8'hFE, 1'b0);

    // Basic operations.
    step("add_zero",  1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
    step("sub_equal", 1'b0, 8'h01, 8'h01, 2'b01, 8'h00, 1'b0);
    step("and_basic", 1'b0, 8'hFF, 8'h01, 2'b10, 8'h01, 1'b0);
    step("or_basic",  1'b0, 8'hFF, 8'h01, 2'b11, 8'hFF, 1'b0);

    // ADD overflow and wrap.
    step("add_pos_ovf",  1'b0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b1);
    step("add_neg_ovf",  1'b0, 8'h80, 8'h80, 2'b00, 8'h00, 1'b1);
    step("add_carry",    1'b0, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b0);

    // SUB overflow.
    step("sub_neg_ovf",  1'b0, 8'h80, 8'h01, 2'b01, 8'h7F, 1'b1);
    step("sub_pos_ovf",  1'b0, 8'h7F, 8'hFF, 2'b01, 8'h80, 1'b1);
    step("sub_borrow",   1'b0, 8'h00, 8'h01, 2'b01, 8'hFF, 1'b0);

    // Logic ops never flag, even right after an overflowing ADD.
    step("add_before_and", 1'b0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b1);
    step("and_no_ovf",     1'b0, 8'h80, 8'h80, 2'b10, 8'h80, 1'b0);
    step("add_before_or",  1'b0, 8'h80, 8'h80, 2'b00, 8'h00, 1'b1);
    step("or_no_ovf",      1'b0, 8'h80, 8'h80, 2'b11, 8'h80, 1'b0);

    // Mid-stream reset discards the operation sampled at the reset edge.
    step("midrst_add",  1'b0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b1);
    step("midrst_edge", 1'b1, 8'h7F, 8'h01, 2'b00, 8'h00, 1'b0);
    step("midrst_after", 1'b0, 8'h40, 8'h40, 2'b00, 8'h80, 1'b1);

    // Randomized run, with operand corners weighted in and occasional reset.
    for (int i = 0; i < 1000; i++) begin
      rst_r = ($urandom_range(31) == 0);
      case ($urandom_range(3))
        0: ra = 8'h7F;
        1: ra = 8'h80;
        default: ra = 8'($urandom);
      endcase
      case ($urandom_range(3))
        0: rb = 8'h01;
        1: rb = 8'hFF;
        default: rb = 8'($urandom);
      endcase
      rop = 2'($urandom);
      expected = model(ra, rb, rop, rst_r);
      step("random", rst_r, ra, rb, rop, expected[7:0], expected[8]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
